reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter MAX_PEND, default 3: maximum in-flight pending writes per register (counter width 2 bits).
REQ-002 Parameter CNT_W, default 16: width of stall performance counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 issue_valid  in  1  decode presents an instruction this cycle.
REQ-006 issue_we  in  1  presented instruction writes a destination register.
REQ-007 issue_rd  in  3  destination register address.
REQ-008 src1_valid / src2_valid  in  1 each  corresponding source operand used.
REQ-009 src1_addr / src2_addr  in  3 each  source register addresses.
REQ-010 wb_valid  in  1  writeback stage retires a register write this cycle.
REQ-011 wb_addr  in  3  register being written back.
REQ-012 flush  in  1  pipeline flush; discard all pending-write tracking.
REQ-013 stall  out  1  decode must hold; instruction not accepted.
REQ-014 busy_mask  out  8  registered; bit i = register i has a pending write.
REQ-015 err_underflow  out  1  sticky; writeback to register with zero pending count.
REQ-016 stall_cycles  out  CNT_W  registered saturating count of stall cycles.

Function
REQ-017 Block SHALL hold one 2-bit pending counter per register, pend[0..7].
REQ-018 stall SHALL be combinational: issue_valid AND (src1 hazard OR src2 hazard OR dest saturation); never asserted while rst=0 or flush=1.
REQ-019 srcN hazard SHALL be srcN_valid AND pend[srcN_addr] != 0, using current (pre-edge) counter values; no same-cycle writeback bypass.
REQ-020 Dest saturation SHALL be issue_we AND pend[issue_rd] == MAX_PEND.
REQ-021 Issue accepted SHALL mean issue_valid AND issue_we AND NOT stall AND NOT flush; accepted issue increments pend[issue_rd] at next edge.
REQ-022 wb_valid with pend[wb_addr] != 0 SHALL decrement pend[wb_addr] at next edge.
REQ-023 wb_valid with pend[wb_addr] == 0 SHALL leave counter at 0 and set err_underflow at next edge.
REQ-024 Accepted issue and writeback to same register in same cycle SHALL leave that counter unchanged; neither saturation nor underflow flagged (increment applies first when count is 0).
REQ-025 Accepted issue and writeback to different registers in same cycle SHALL both take effect.
REQ-026 flush SHALL clear all pend[] to 0 at next edge, overriding any same-cycle issue or writeback; no underflow flagged that cycle.
REQ-027 Writebacks after flush for flushed entries SHALL follow REQ-023 (err_underflow set); this is reported, not masked.
REQ-028 busy_mask SHALL be updated every edge as (pend[i] != 0) of the new counter values; one-cycle latency after the causing event.
REQ-029 stall_cycles SHALL increment by 1 on each edge where stall=1, saturating at all-ones.
REQ-030 err_underflow SHALL remain set until reset; flush does not clear it.
REQ-031 Counters SHALL never exceed MAX_PEND nor wrap below 0.

Reset
REQ-032 While rst=0 at a rising edge: pend[] all 0, busy_mask=8'h00, err_underflow=0, stall_cycles=0.
REQ-033 While rst=0, stall SHALL be 0 and issue/writeback inputs ignored.
REQ-034 Reset mid-operation SHALL discard all pending state with no error reporting; first edge with rst=1 operates from the cleared state.

Verification
REQ-035 Issue we=1 rd=3, next cycle issue src1=3 -> stall=1, busy_mask=8'h08; wb_addr=3 -> next cycle stall=0, busy_mask=8'h00.
REQ-036 Three accepted issues to rd=5 -> pend[5]=3; fourth issue rd=5 -> stall=1, stall_cycles increments; one wb to 5 -> fourth issue accepted next cycle.
REQ-037 pend[2]=1, same cycle issue rd=2 and wb_addr=2 -> pend[2] stays 1, busy_mask[2]=1, err_underflow=0.
REQ-038 pend[1]=2, pend[6]=1, flush with simultaneous issue rd=4 -> busy_mask=8'h00 next cycle; later wb_addr=1 -> err_underflow=1 and stays 1.
REQ-039 Source read of register 7 with wb_addr=7 same cycle (pend[7]=1) -> stall=1 that cycle, stall=0 next cycle.
REQ-040 Drive rst=0 with pend[0]=2 and stall_cycles=10 -> after edge all outputs 0; stall=0 during reset regardless of inputs.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register,
// stalls decode on RAW hazards or a saturated destination counter, and
// reports writebacks that retire a register with nothing pending.

// Per-register pending-write counter with issue/writeback/flush arbitration.
module reg_pend_cnt #(
    parameter int MAX_PEND = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] cnt,
    output logic [1:0] cnt_nxt,
    output logic       underflow
);
    localparam logic [1:0] SAT = 2'(MAX_PEND);

    // Next count; a paired issue+writeback cancels out, even from zero.
    always_comb begin
        cnt_nxt   = cnt;
        underflow = 1'b0;
        if (flush) begin
            cnt_nxt = 2'd0;
        end else if (inc && dec) begin
            cnt_nxt = cnt;
        end else if (inc) begin
            if (cnt != SAT) cnt_nxt = cnt + 2'd1;
        end else if (dec) begin
            if (cnt != 2'd0) cnt_nxt = cnt - 2'd1;
            else             underflow = 1'b1;
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) cnt <= 2'd0;
        else      cnt <= cnt_nxt;
    end
endmodule

module reg_scoreboard #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_we,
    input  logic [2:0]       issue_rd,
    input  logic             src1_valid,
    input  logic [2:0]       src1_addr,
    input  logic             src2_valid,
    input  logic [2:0]       src2_addr,
    input  logic             wb_valid,
    input  logic [2:0]       wb_addr,
    input  logic             flush,
    output logic             stall,
    output logic [7:0]       busy_mask,
    output logic             err_underflow,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [1:0] SAT = 2'(MAX_PEND);

    logic [7:0][1:0] pend;
    logic [7:0][1:0] pend_nxt;
    logic [7:0]      inc;
    logic [7:0]      dec;
    logic [7:0]      uf;
    logic            hz1, hz2, dsat, accept;

    // Hazard detection uses pre-edge counters only; no writeback bypass.
    always_comb begin
        hz1    = src1_valid && (pend[src1_addr] != 2'd0);
        hz2    = src2_valid && (pend[src2_addr] != 2'd0);
        dsat   = issue_we && (pend[issue_rd] == SAT);
        stall  = rst && !flush && issue_valid && (hz1 || hz2 || dsat);
        accept = rst && !flush && issue_valid && issue_we && !stall;
    end

    genvar i;
    generate
        for (i = 0; i < 8; i++) begin : g_reg
            assign inc[i] = accept && (issue_rd == 3'(i));
            assign dec[i] = rst && wb_valid && (wb_addr == 3'(i));

            reg_pend_cnt #(.MAX_PEND(MAX_PEND)) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .inc       (inc[i]),
                .dec       (dec[i]),
                .cnt       (pend[i]),
                .cnt_nxt   (pend_nxt[i]),
                .underflow (uf[i])
            );
        end
    endgenerate

    // Busy mask mirrors the post-edge counters; sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_mask     <= 8'h00;
            err_underflow <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) busy_mask[k] <= (pend_nxt[k] != 2'd0);
            if (|uf) err_underflow <= 1'b1;
        end
    end

    // Saturating stall-cycle performance counter.
    always_ff @(posedge clk) begin
        if (!rst)                         stall_cycles <= '0;
        else if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: a behavioural model predicts stall
// combinationally and queues the registered outputs expected after each edge.
module tb_reg_scoreboard;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, issue_valid, issue_we, src1_valid, src2_valid, wb_valid, flush;
    logic [2:0]    issue_rd, src1_addr, src2_addr, wb_addr;
    logic          stall, err_underflow;
    logic [7:0]    busy_mask;
    logic [CW-1:0] stall_cycles;

    typedef struct {
        logic [7:0]    busy;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   mp[8];
    bit   merr;
    int   mcnt;
    int   n_tests = 0;
    int   n_fail  = 0;

    reg_scoreboard #(.MAX_PEND(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_rd(issue_rd), .src1_valid(src1_valid), .src1_addr(src1_addr),
        .src2_valid(src2_valid), .src2_addr(src2_addr), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .flush(flush), .stall(stall), .busy_mask(busy_mask),
        .err_underflow(err_underflow), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check stall, predict, clock, check registered outputs.
    task automatic cyc(input bit r, input bit iv, input bit we, input int rd,
                       input bit s1v, input int s1a, input bit s2v, input int s2a,
                       input bit wv, input int wa, input bit fl);
        bit   st, acc;
        exp_t e, o;
        rst = r; issue_valid = iv; issue_we = we; issue_rd = 3'(rd);
        src1_valid = s1v; src1_addr = 3'(s1a); src2_valid = s2v; src2_addr = 3'(s2a);
        wb_valid = wv; wb_addr = 3'(wa); flush = fl;
        #2;
        st = r && !fl && iv && ((s1v && mp[s1a] != 0) || (s2v && mp[s2a] != 0) ||
                                (we && mp[rd] == 3));
        chk("stall", 32'(stall), 32'(st));
        if (!r) begin
            foreach (mp[k]) mp[k] = 0;
            merr = 0;
            mcnt = 0;
        end else begin
            if (st && mcnt < (1 << CW) - 1) mcnt++;
            if (fl) begin
                foreach (mp[k]) mp[k] = 0;
            end else begin
                acc = iv && we && !st;
                if (!(acc && wv && rd == wa)) begin
                    if (acc) mp[rd]++;
                    if (wv) begin
                        if (mp[wa] > 0) mp[wa]--;
                        else            merr = 1;
                    end
                end
            end
        end
        foreach (mp[k]) e.busy[k] = (mp[k] != 0);
        e.err = merr;
        e.cnt = CW'(mcnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            o = exp_q.pop_front();
            chk("busy_mask", 32'(busy_mask), 32'(o.busy));
            chk("err_underflow", 32'(err_underflow), 32'(o.err));
            chk("stall_cycles", 32'(stall_cycles), 32'(o.cnt));
        end
    endtask

    task automatic idle(input bit r);
        cyc(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (mp[k]) mp[k] = 0;
        merr = 0;
        mcnt = 0;
        @(posedge clk);
        #1;
        idle(0);
        idle(0);
        chk("reset_busy_const", 32'(busy_mask), 32'h00);
        idle(1);

        // RAW on r3, cleared by writeback
        cyc(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("raw_busy08", 32'(busy_mask), 32'h08);
        cyc(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        chk("raw_busy00", 32'(busy_mask), 32'h00);
        cyc(1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);

        // Saturate r5, fourth issue stalls until one writeback
        repeat (3) cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

        // Same-cycle issue+writeback to r2 with pend=1, then from pend=0
        cyc(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        chk("pair_busy2", 32'(busy_mask[2]), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        cyc(1, 1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
        chk("pair_noerr", 32'(err_underflow), 32'd0);

        // Issue and writeback to different registers
        cyc(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 4, 0);
        idle(1);

        // Flush overriding issue, then underflow after flush stays sticky
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 4, 0, 0, 0, 0, 1, 6, 1);
        chk("flush_busy", 32'(busy_mask), 32'h00);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("err_set", 32'(err_underflow), 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // No bypass: writeback to r7 does not clear the same-cycle hazard
        cyc(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        cyc(1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0);

        // Reset mid-operation with hazard-causing inputs asserted
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 1, 0, 1, 3, 0);
        cyc(0, 1, 1, 0, 1, 0, 1, 0, 1, 3, 0);
        chk("rst_cnt0", 32'(stall_cycles), 32'd0);
        idle(1);

        // Constrained-random traffic; long stall runs saturate the counter
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 60) != 0, $urandom % 4 != 0, $urandom % 2,
                int'($urandom % 8), $urandom % 2, int'($urandom % 8),
                $urandom % 2, int'($urandom % 8), $urandom % 3 == 0,
                int'($urandom % 8), ($urandom % 25) == 0);
        end

        if (exp_q.size() != 0) chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
